mem_stage_lsu: RTL
==================

// Module: mem_stage_lsu
// PURPOSE
//  Memory-stage load/store unit. Sits between the EX/MEM pipeline register and the MEM/WB register.
//  Drives data memory over a req/ack handshake, builds byte enables and store lanes, and
//  aligns/extends load data into read_data_M for the MEM/WB register.
//  Raises stall_M while an access is outstanding. While stall_M=1 the hazard unit freezes IF..EX/MEM
//  and forces rd_wren_M=0 into MEM/WB.
// PARAMETERS
//  MAX_WAIT  15  cycles in WAIT without dmem_ack before the access is abandoned (1..255)
// PORTS
//  i_clk         in   1   clock, rising edge
//  i_rst         in   1   asynchronous, active-high reset
//  alu_data_M    in   32  effective address from EX/MEM
//  store_data_M  in   32  rs2 value for stores
//  mem_rden_M    in   1   load in MEM stage
//  mem_wren_M    in   1   store in MEM stage
//  funct3_M      in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  read_data_M   out  32  aligned/extended load result to MEM/WB
//  stall_M       out  1   MEM stage busy; upstream must hold
//  misalign_M    out  1   current access misaligned (combinational)
//  timeout_err   out  1   sticky: an access hit MAX_WAIT
//  dmem_req      out  1   memory request
//  dmem_we       out  1   1=write, 0=read
//  dmem_addr     out  32  word address ({alu_data_M[31:2],2'b00})
//  dmem_wdata    out  32  store data, lane-replicated
//  dmem_be       out  4   byte enables
//  dmem_ack      in   1   request accepted/completed this cycle
//  dmem_rdata    in   32  read word; valid with dmem_ack
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, wait counter=0. All outputs 0, including read_data_M and timeout_err.
//   An outstanding request is dropped immediately.
//  access = mem_rden_M|mem_wren_M. If both are 1, treat as store. funct3 011/110/111 treated as W.
//  Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
//   Response: misalign_M=1, no request, stall_M=0, state stays IDLE, read_data_M unchanged.
//  FSM IDLE/WAIT/DONE:
//   IDLE: aligned access -> stall_M=1 (comb). Latch we/addr/wdata/be/funct3/addr[1:0]; next WAIT.
//         No access -> stall_M=0; stay IDLE.
//   WAIT: dmem_req=1; dmem_we/addr/wdata/be held stable from the latched values; stall_M=1;
//         counter increments each cycle.
//         dmem_ack=1 -> load: read_data_M <= formatted dmem_rdata; store: read_data_M unchanged; next DONE.
//         Ack is legal in the first WAIT cycle.
//         counter==MAX_WAIT-1 with no ack -> timeout_err<=1, read_data_M<=0, req dropped; next DONE.
//   DONE: stall_M=0, dmem_req=0; read_data_M valid for MEM/WB capture at this edge; next IDLE unconditionally.
//         No relaunch, even though EX/MEM still holds the same access.
//  dmem_ack outside WAIT: ignored. timeout_err is cleared only by reset.
//  Min occupancy of an aligned access in MEM: 3 cycles (IDLE, WAIT, DONE). Non-memory ops: 1 cycle.
//  Store lanes/BE (a=addr[1:0]):
//   B: wdata={4{st[7:0]}}, be=4'b0001<<a. H: wdata={2{st[15:0]}}, be=a[1]?1100:0011. W: wdata=st, be=1111.
//  Load format: byte=rdata[8a+:8], half=rdata[16a[1]+:16].
//   B/H sign-extend, BU/HU zero-extend, W passthrough.
//  dmem outputs are 0 whenever dmem_req=0.
// TESTING
//  LW addr 0x100, ack 2nd WAIT cycle, rdata 0xDEADBEEF -> stall 1,1,1 then 0; read_data_M=0xDEADBEEF in DONE.
//  LB addr 0x103 rdata 0x80FF0000 -> 0xFFFFFF80. LBU same -> 0x00000080.
//   LH addr 0x102 rdata 0x8001xxxx -> 0xFFFF8001.
//  SB addr 0x202 st 0x000000AB -> dmem_we=1, be=0100, wdata=0xABABABAB, held until ack.
//  LW addr 0x101 -> misalign_M=1, dmem_req=0, stall_M=0.
//   SH addr 0x203 -> same response. SH addr 0x202 -> be=1100.
//  No ack, MAX_WAIT=15 -> req high 15 cycles, then timeout_err=1 (sticky), read_data_M=0, stall drops in DONE.
//  i_rst pulsed mid-WAIT -> req/stall/outputs 0 immediately; after release an ack is ignored; state IDLE.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: drives the data-memory req/ack handshake,
// builds store lanes and byte enables, and aligns/extends load data for MEM/WB.
module mem_stage_lsu #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] alu_data_M,
    input  logic [31:0] store_data_M,
    input  logic        mem_rden_M,
    input  logic        mem_wren_M,
    input  logic [2:0]  funct3_M,
    output logic [31:0] read_data_M,
    output logic        stall_M,
    output logic        misalign_M,
    output logic        timeout_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;

    logic        access;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        misal;
    logic        go;
    logic [31:0] st_wdata;
    logic [3:0]  lane_be;
    logic [31:0] rd_sh;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    // Decode the incoming access: size, alignment, lanes and byte enables.
    always_comb begin
        access   = mem_rden_M | mem_wren_M;
        is_byte  = (funct3_M[1:0] == 2'b00);
        is_half  = (funct3_M[1:0] == 2'b01);
        is_word  = funct3_M[1];
        misal    = (is_half & alu_data_M[0]) | (is_word & (|alu_data_M[1:0]));
        go       = access & ~misal;
        st_wdata = store_data_M;
        lane_be  = 4'b1111;
        if (is_byte) begin
            st_wdata = {4{store_data_M[7:0]}};
            lane_be  = 4'b0001 << alu_data_M[1:0];
        end else if (is_half) begin
            st_wdata = {2{store_data_M[15:0]}};
            lane_be  = alu_data_M[1] ? 4'b1100 : 4'b0011;
        end
    end

    // Status outputs are forced low while reset is asserted.
    always_comb begin
        misalign_M = ~i_rst & access & misal;
        stall_M    = ~i_rst & (((state == S_IDLE) & go) | (state == S_WAIT));
    end

    // Select and extend the addressed byte/half of the returned word.
    always_comb begin
        rd_sh   = dmem_rdata >> {off_q, 3'b000};
        ld_byte = rd_sh[7:0];
        ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q[1:0])
            2'b00:   ld_fmt = f3_q[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_fmt = f3_q[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_fmt = dmem_rdata;
        endcase
    end

    // Access FSM: launch from IDLE, hold request in WAIT, one DONE cycle for MEM/WB capture.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            read_data_M <= '0;
            timeout_err <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            dmem_be     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state      <= S_WAIT;
                        wait_cnt   <= '0;
                        f3_q       <= funct3_M;
                        off_q      <= alu_data_M[1:0];
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_wren_M;
                        dmem_addr  <= {alu_data_M[31:2], 2'b00};
                        dmem_wdata <= mem_wren_M ? st_wdata : 32'd0;
                        dmem_be    <= lane_be;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack || (wait_cnt == WAIT_LAST)) begin
                        if (dmem_ack) begin
                            if (!dmem_we) begin
                                read_data_M <= ld_fmt;
                            end
                        end else begin
                            timeout_err <= 1'b1;
                            read_data_M <= '0;
                        end
                        state      <= S_DONE;
                        wait_cnt   <= '0;
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        dmem_addr  <= '0;
                        dmem_wdata <= '0;
                        dmem_be    <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
